// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: datapath widths, the NOP
// encoding and the {PC, instruction} packet passed from fetch to decode.
package mips_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {PC, instruction} with a single-cycle flush.
// Optional INST_QUEUE_BYPASS_EN adds a zero-latency path from push_* to pop_* when the queue is empty.
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [INST_W-1:0]          push_inst,
  output logic                       push_ready,
  input  logic                       flush,
  output logic                       pop_valid,
  output logic [ADDR_W-1:0]          pop_addr,
  output logic [INST_W-1:0]          pop_inst,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import mips_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  fetch_pkt_t mem_q [DEPTH];
  fetch_pkt_t wr_pkt;
  fetch_pkt_t head_pkt;

  logic bypass;
  logic push_acc;
  logic pop_acc;
  logic direct;
  logic do_wr;
  logic do_rd;

  always_comb begin
    bypass = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass = (count_q == '0) && !flush && push_valid;
`endif

    wr_pkt.addr = push_addr;
    wr_pkt.inst = push_inst;

    push_ready = (count_q != CNT_W'(DEPTH));
    pop_valid  = (count_q != '0) || bypass;

    head_pkt = bypass ? wr_pkt : mem_q[rd_ptr_q];
    pop_addr = pop_valid ? head_pkt.addr : '0;
    pop_inst = pop_valid ? head_pkt.inst : NOP_INST;

    push_acc = push_valid && push_ready;
    pop_acc  = pop_valid && pop_ready;

    // A bypassed entry that decode takes immediately never touches storage.
    direct = bypass && pop_ready;
    do_wr  = push_acc && !direct && !flush;
    do_rd  = pop_acc  && !direct && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
      if (do_rd) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      case ({do_wr, do_rd})
        2'b10:   count_d = CNT_W'(count_q + 1'b1);
        2'b01:   count_d = CNT_W'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem_q[wr_ptr_q] <= wr_pkt;
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: ordering, full/empty boundaries, pointer wrap,
// flush, mid-stream reset and the optional INST_QUEUE_BYPASS_EN path.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic [15:0] push_addr;
  logic [15:0] push_inst;
  logic        push_ready;
  logic        flush;
  logic        pop_valid;
  logic [15:0] pop_addr;
  logic [15:0] pop_inst;
  logic        pop_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(4), .ADDR_W(16), .INST_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_addr  (push_addr),
    .push_inst  (push_inst),
    .push_ready (push_ready),
    .flush      (flush),
    .pop_valid  (pop_valid),
    .pop_addr   (pop_addr),
    .pop_inst   (pop_inst),
    .pop_ready  (pop_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [15:0] a, input logic [15:0] i);
    push_valid = v;
    push_addr  = a;
    push_inst  = i;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pop_ready = 1'b0;
    drive_push(1'b0, 16'h0, 16'h0);
    cyc();
    cyc();
    check("rst_count", 32'(count), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_addr", 32'(pop_addr), 32'd0);
    check("rst_pop_inst", 32'(pop_inst), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    rst = 1'b0;

    // Three pushes with decode stalled, then drain in order.
    drive_push(1'b1, 16'h0000, 16'h1234); cyc();
    drive_push(1'b1, 16'h0002, 16'h5678); cyc();
    drive_push(1'b1, 16'h0004, 16'h9ABC); cyc();
    drive_push(1'b0, 16'h0, 16'h0);
    check("t1_count3", 32'(count), 32'd3);
    check("t1_head_valid", 32'(pop_valid), 32'd1);
    pop_ready = 1'b1;
    check("t1_pop0_inst", 32'(pop_inst), 32'h1234);
    check("t1_pop0_addr", 32'(pop_addr), 32'h0000);
    cyc();
    check("t1_pop1_inst", 32'(pop_inst), 32'h5678);
    check("t1_pop1_addr", 32'(pop_addr), 32'h0002);
    cyc();
    check("t1_pop2_inst", 32'(pop_inst), 32'h9ABC);
    check("t1_count1", 32'(count), 32'd1);
    cyc();
    check("t1_empty_valid", 32'(pop_valid), 32'd0);
    check("t1_empty_inst", 32'(pop_inst), 32'd0);
    check("t1_empty_addr", 32'(pop_addr), 32'd0);
    check("t1_empty_count", 32'(count), 32'd0);
    pop_ready = 1'b0;

    // Fill to DEPTH, then a rejected push, then full push+pop.
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 16'(16'h0010 + 2*i), 16'(16'hA000 + i));
      cyc();
    end
    check("t2_full_count", 32'(count), 32'd4);
    check("t2_full_ready", 32'(push_ready), 32'd0);
    drive_push(1'b1, 16'h0018, 16'hA004);
    cyc();
    check("t2_reject_count", 32'(count), 32'd4);
    check("t2_reject_head", 32'(pop_inst), 32'hA000);
    pop_ready = 1'b1;
    cyc();
    check("t2_fullpp_count", 32'(count), 32'd3);
    check("t2_fullpp_head", 32'(pop_inst), 32'hA001);
    check("t2_fullpp_ready", 32'(push_ready), 32'd1);
    cyc();
    check("t2_pp_count", 32'(count), 32'd3);
    check("t2_pp_head", 32'(pop_inst), 32'hA002);
    drive_push(1'b0, 16'h0, 16'h0);
    cyc();
    check("t2_pop_count", 32'(count), 32'd2);
    check("t2_pop_head", 32'(pop_inst), 32'hA003);
    cyc();
    check("t2_last_head", 32'(pop_inst), 32'hA004);
    check("t2_last_addr", 32'(pop_addr), 32'h0018);
    cyc();
    check("t2_drained", 32'(count), 32'd0);
    pop_ready = 1'b0;

    // Streaming push+pop at count 1; pointers wrap repeatedly.
    drive_push(1'b1, 16'h0000, 16'hB000);
    cyc();
    check("t3_prime_count", 32'(count), 32'd1);
    pop_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      drive_push(1'b1, 16'(2*i), 16'(16'hB000 + i));
      check("t3_stream_head", 32'(pop_inst), 32'(16'hB000 + i - 1));
      check("t3_stream_addr", 32'(pop_addr), 32'(2*(i-1)));
      cyc();
      check("t3_stream_count", 32'(count), 32'd1);
    end
    drive_push(1'b0, 16'h0, 16'h0);
    check("t3_tail_head", 32'(pop_inst), 32'hB009);
    cyc();
    check("t3_tail_count", 32'(count), 32'd0);
    pop_ready = 1'b0;

    // Flush with a simultaneous push: everything discarded.
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 16'(16'h0030 + 2*i), 16'(16'hC000 + i));
      cyc();
    end
    check("t4_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive_push(1'b1, 16'h0040, 16'hC040);
    cyc();
    flush = 1'b0;
    drive_push(1'b0, 16'h0, 16'h0);
    check("t4_flush_count", 32'(count), 32'd0);
    check("t4_flush_valid", 32'(pop_valid), 32'd0);
    check("t4_flush_inst", 32'(pop_inst), 32'd0);
    pop_ready = 1'b1;
    cyc();
    check("t4_still_empty", 32'(pop_valid), 32'd0);
    pop_ready = 1'b0;
    drive_push(1'b1, 16'h0050, 16'hD000);
    cyc();
    check("t4_after_count", 32'(count), 32'd1);
    check("t4_after_head", 32'(pop_inst), 32'hD000);
    check("t4_after_addr", 32'(pop_addr), 32'h0050);

    // Reset mid-stream with two entries held.
    drive_push(1'b1, 16'h0052, 16'hD001);
    cyc();
    drive_push(1'b0, 16'h0, 16'h0);
    check("t5_pre_count", 32'(count), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(pop_valid), 32'd0);
    check("t5_ready", 32'(push_ready), 32'd1);

    // Push into an empty queue with decode ready.
    pop_ready = 1'b1;
    drive_push(1'b1, 16'h0010, 16'h2222);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("t6_same_valid", 32'(pop_valid), 32'd1);
    check("t6_same_inst", 32'(pop_inst), 32'h2222);
    check("t6_same_addr", 32'(pop_addr), 32'h0010);
`else
    check("t6_same_valid", 32'(pop_valid), 32'd0);
    check("t6_same_inst", 32'(pop_inst), 32'd0);
`endif
    cyc();
    drive_push(1'b0, 16'h0, 16'h0);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("t6_next_count", 32'(count), 32'd0);
    check("t6_next_valid", 32'(pop_valid), 32'd0);
`else
    check("t6_next_count", 32'(count), 32'd1);
    check("t6_next_inst", 32'(pop_inst), 32'h2222);
    check("t6_next_addr", 32'(pop_addr), 32'h0010);
`endif
    cyc();
    check("t6_final_count", 32'(count), 32'd0);
    check("t6_final_valid", 32'(pop_valid), 32'd0);
    pop_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
